led_bank_ctrl: RTL and testbench

//  Parametrised LED bank driver for the Wordle board: NUM_CH letter LEDs, each
//  off/on/slow-blink/fast-blink from a 3-bit mode code, plus warning and 2-bit game-state LEDs.

---
 rtl/led_bank_ctrl.sv | 158 +++++++++++++++
 tb/tb_led_bank_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/led_bank_ctrl.sv
// Wordle LED bank: per-channel on/off/blink decode, shared blink prescalers, timed reveal sweep.
// Optional LED_PWM_EN adds brightness_i and a PWM gate on lit letter LEDs.
module led_bank_ctrl #(
   parameter int NUM_CH     = 5,
   parameter int SLOW_DIV   = 20_000_000,
   parameter int FAST_DIV   = 5_000_000,
   parameter int REVEAL_DIV = 10_000_000,
   parameter int PWM_BITS   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3*NUM_CH-1:0] mode_i,
   input  logic                reveal_start,
   input  logic                warning,
   input  logic [1:0]          state,
`ifdef LED_PWM_EN
   input  logic [PWM_BITS-1:0] brightness_i,
`endif
   output logic [NUM_CH-1:0]   led_o,
   output logic                warn_led,
   output logic [1:0]          state_led,
   output logic                reveal_busy,
   output logic                reveal_done
);

   localparam int SW = $clog2(SLOW_DIV);
   localparam int FW = $clog2(FAST_DIV);
   localparam int TW = $clog2(REVEAL_DIV);
   localparam int RW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [SW-1:0] SLOW_MAX = SW'(SLOW_DIV - 1);
   localparam logic [FW-1:0] FAST_MAX = FW'(FAST_DIV - 1);
   localparam logic [TW-1:0] TICK_MAX = TW'(REVEAL_DIV - 1);
   localparam logic [RW-1:0] R_LAST   = RW'(NUM_CH - 1);

   if (PWM_BITS < 1) begin : g_bad_pwm_bits
   end

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} fsm_t;

   fsm_t            fsm, fsm_n;
   logic [RW-1:0]   r, r_n;
   logic [TW-1:0]   tick, tick_n;
   logic            tick_wrap;
   logic [SW-1:0]   slow_cnt;
   logic [FW-1:0]   fast_cnt;
   logic            slow_ph, fast_ph;
   logic [NUM_CH-1:0] lit, show, led_n;

   // One prescaler pair for the whole bank keeps all blinking channels in phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slow_cnt <= '0;
         slow_ph  <= 1'b0;
         fast_cnt <= '0;
         fast_ph  <= 1'b0;
      end else begin
         if (slow_cnt == SLOW_MAX) begin
            slow_cnt <= '0;
            slow_ph  <= ~slow_ph;
         end else begin
            slow_cnt <= slow_cnt + 1'b1;
         end
         if (fast_cnt == FAST_MAX) begin
            fast_cnt <= '0;
            fast_ph  <= ~fast_ph;
         end else begin
            fast_cnt <= fast_cnt + 1'b1;
         end
      end
   end

   assign tick_wrap = (tick == TICK_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm  <= IDLE;
         r    <= '0;
         tick <= '0;
      end else begin
         fsm  <= fsm_n;
         r    <= r_n;
         tick <= tick_n;
      end
   end

   always_comb begin
      fsm_n  = fsm;
      r_n    = r;
      tick_n = tick;
      case (fsm)
         IDLE: begin
            if (reveal_start) begin
               fsm_n  = SWEEP;
               r_n    = '0;
               tick_n = '0;
            end
         end
         SWEEP: begin
            if (tick_wrap) begin
               tick_n = '0;
               if (r == R_LAST) fsm_n = DONE;
               else             r_n   = r + 1'b1;
            end else begin
               tick_n = tick + 1'b1;
            end
         end
         DONE:    fsm_n = IDLE;
         default: fsm_n = IDLE;
      endcase
   end

   // Mask uses next-state so the first sweep frame appears on the edge that accepts reveal_start.
   always_comb begin
      lit  = '0;
      show = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         case (mode_i[3*k +: 3])
            3'b100:  lit[k] = 1'b1;
            3'b010:  lit[k] = slow_ph;
            3'b011:  lit[k] = fast_ph;
            default: lit[k] = 1'b0;
         endcase
         show[k] = (fsm_n != SWEEP) || (k <= int'(r_n));
      end
   end

`ifdef LED_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                pwm_on;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pwm_cnt <= '0;
      else     pwm_cnt <= pwm_cnt + 1'b1;
   end

   assign pwm_on = (&brightness_i) || (pwm_cnt < brightness_i);
   assign led_n  = lit & show & {NUM_CH{pwm_on}};
`else
   assign led_n  = lit & show;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_o       <= '0;
         warn_led    <= 1'b0;
         state_led   <= 2'b00;
         reveal_busy <= 1'b0;
         reveal_done <= 1'b0;
      end else begin
         led_o       <= led_n;
         warn_led    <= warning;
         state_led   <= state;
         reveal_busy <= (fsm_n == SWEEP);
         reveal_done <= (fsm_n == DONE);
      end
   end

endmodule

// File: tb/tb_led_bank_ctrl.sv
// Directed bench for led_bank_ctrl with a small expected-value scoreboard.
module tb_led_bank_ctrl;

   logic        clk;
   logic        rst;
   logic [14:0] mode_i;
   logic        reveal_start;
   logic        warning;
   logic [1:0]  state;
`ifdef LED_PWM_EN
   logic [3:0]  brightness_i;
`endif
   logic [4:0]  led_o;
   logic        warn_led;
   logic [1:0]  state_led;
   logic        reveal_busy;
   logic        reveal_done;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   string       exp_tag[$];
   logic [9:0]  exp_val[$];

   led_bank_ctrl #(
      .NUM_CH(5), .SLOW_DIV(4), .FAST_DIV(2), .REVEAL_DIV(3), .PWM_BITS(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mode_i(mode_i),
      .reveal_start(reveal_start),
      .warning(warning),
      .state(state),
`ifdef LED_PWM_EN
      .brightness_i(brightness_i),
`endif
      .led_o(led_o),
      .warn_led(warn_led),
      .state_led(state_led),
      .reveal_busy(reveal_busy),
      .reveal_done(reveal_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] outs();
      return {reveal_done, reveal_busy, state_led, warn_led, led_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic exp_push(input string t, input logic [9:0] v);
      exp_tag.push_back(t);
      exp_val.push_back(v);
   endtask

   task automatic exp_chk(input logic [9:0] obs);
      string      t;
      logic [9:0] v;
      compared++;
      if (exp_val.size() == 0) begin
         mismatched++;
         $error("FAIL sb_underflow: observed %0h with no expected value", obs);
      end else begin
         t = exp_tag.pop_front();
         v = exp_val.pop_front();
         assert (obs === v) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, v);
         end
      end
   endtask

   initial begin
      int         n;
      logic       s_exp, f_exp;
      logic [4:0] led_exp;
      int         hi;

      rst          = 1'b1;
      mode_i       = {5{3'b100}};
      reveal_start = 1'b0;
      warning      = 1'b1;
      state        = 2'b11;
`ifdef LED_PWM_EN
      brightness_i = 4'hF;
`endif
      #3;
      exp_push("rst_initial", 10'd0);
      exp_chk(outs());
      tick();
      tick();
      exp_push("rst_hold", 10'd0);
      exp_chk(outs());

      rst = 1'b0;
      cyc = 0;
      exp_push("release_pre_edge", 10'd0);
      exp_chk(outs());
      tick();
      exp_push("release_follow", {1'b0, 1'b0, 2'b11, 1'b1, 5'b11111});
      exp_chk(outs());
      tick();
      tick();

      // Asynchronous reset mid-run clears outputs before the next edge.
      #2 rst = 1'b1;
      #1;
      exp_push("rst_async", 10'd0);
      exp_chk(outs());
      tick();
      tick();
      exp_push("rst_async_hold", 10'd0);
      exp_chk(outs());
      rst = 1'b0;
      cyc = 0;

      // Static decode, including the undefined codes 000/101/111.
      warning = 1'b0;
      state   = 2'b00;
      mode_i  = {3'b101, 3'b000, 3'b111, 3'b001, 3'b100};
      for (int i = 0; i < 100; i++) begin
         exp_push("static_decode", {1'b0, 1'b0, 2'b00, 1'b0, 5'b00001});
         tick();
         exp_chk(outs());
      end

      // Blink: phases run from reset release, 4 cycles slow / 2 cycles fast per half-period.
      mode_i = {3'b001, 3'b001, 3'b001, 3'b011, 3'b010};
      for (int i = 0; i < 24; i++) begin
         n     = cyc;
         s_exp = ((n / 4) % 2) == 1;
         f_exp = ((n / 2) % 2) == 1;
         exp_push("blink", {1'b0, 1'b0, 2'b00, 1'b0, 3'b000, f_exp, s_exp});
         tick();
         exp_chk(outs());
      end

      // Reveal sweep, with a second reveal_start mid-sweep that must be ignored.
      mode_i = {5{3'b100}};
      exp_push("pre_sweep", {1'b0, 1'b0, 2'b00, 1'b0, 5'b11111});
      tick();
      exp_chk(outs());
      for (int j = 0; j < 18; j++) begin
         reveal_start = (j == 0) || (j == 5);
         n       = (j >= 15) ? 5 : (j / 3) + 1;
         led_exp = 5'((1 << n) - 1);
         exp_push("sweep", {(j == 15), (j < 15), 2'b00, 1'b0, led_exp});
         tick();
         exp_chk(outs());
      end
      reveal_start = 1'b0;

      // Warning and game-state passthrough for every state code.
      for (int s = 0; s < 4; s++) begin
         warning = (s % 2) == 0;
         state   = 2'(3 - s);
         exp_push("status", {1'b0, 1'b0, 2'(3 - s), ((s % 2) == 0), 5'b11111});
         tick();
         exp_chk(outs());
      end
      warning = 1'b1;
      state   = 2'b10;
      exp_push("status_w1_s2", {1'b0, 1'b0, 2'b10, 1'b1, 5'b11111});
      tick();
      exp_chk(outs());
      state = 2'b00;
      exp_push("status_s0", {1'b0, 1'b0, 2'b00, 1'b1, 5'b11111});
      tick();
      exp_chk(outs());

`ifdef LED_PWM_EN
      mode_i = {3'b001, 3'b001, 3'b001, 3'b001, 3'b100};
      for (int b = 0; b < 3; b++) begin
         brightness_i = (b == 0) ? 4'd4 : ((b == 1) ? 4'd15 : 4'd0);
         tick();
         hi = 0;
         for (int i = 0; i < 16; i++) begin
            tick();
            if (led_o[0]) hi++;
         end
         exp_push("pwm_high_count", (b == 0) ? 10'd4 : ((b == 1) ? 10'd16 : 10'd0));
         exp_chk(10'(hi));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
